fpu_i2f_cvt: RTL

Parametrised integer-to-IEEE-754 single-precision converter for the FPU execute path; successor to the fixed 32-bit signed converter. Supports 32- or 64-bit integer sources, signed/unsigned operation per request, all five RISC-V rounding modes and the inexact flag. Fixed latency, one request in flight, same dval/rdy pulse handshake as the other FPU units.

---
 rtl/fpu_i2f_cvt_pkg.sv | 42 ++++
 rtl/fpu_i2f_cvt_if.sv | 24 ++
 rtl/fpu_i2f_cvt_lzc.sv | 19 +
 rtl/fpu_i2f_cvt.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fpu_i2f_cvt_pkg.sv
// Shared FPU constants: rounding-mode encodings, fflags bit positions, SP format, i2f FSM states.
// Also holds the rounding-increment decision so later converters can reuse it.
package fpu_i2f_cvt_pkg;

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   localparam int FFLAG_NX = 0;
   localparam int FFLAG_UF = 1;
   localparam int FFLAG_OF = 2;
   localparam int FFLAG_DZ = 3;
   localparam int FFLAG_NV = 4;

   localparam int SP_BIAS   = 127;
   localparam int SP_MANT_W = 24;

   typedef enum logic [2:0] {
      I2F_IDLE,
      I2F_ABS,
      I2F_NORM,
      I2F_ROUND,
      I2F_PACK
   } i2f_state_e;

   // Unknown encodings fall back to RNE; trapping them is left to the decoder.
   function automatic logic round_inc(input logic [2:0] rm, input logic s,
                                      input logic lsb, input logic g, input logic st);
      logic inc;
      case (rm)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = s & (g | st);
         RM_RUP:  inc = !s & (g | st);
         RM_RMM:  inc = g;
         default: inc = g & (st | lsb);
      endcase
      return inc;
   endfunction

endpackage

// File: rtl/fpu_i2f_cvt_if.sv
// Request/response bundle of the integer-to-float converter.
// The master issues dval-qualified operands; the slave returns result/fflags with a rdy pulse.
interface fpu_i2f_cvt_if #(parameter int IW = 32);

   logic [IW-1:0] din;
   logic          dval;
   logic          is_unsigned;
   logic [2:0]    rm;
   logic [31:0]   result;
   logic [4:0]    fflags;
   logic          rdy;
   logic          busy;

   modport master (
      output din, dval, is_unsigned, rm,
      input  result, fflags, rdy, busy
   );

   modport slave (
      input  din, dval, is_unsigned, rm,
      output result, fflags, rdy, busy
   );

endinterface

// File: rtl/fpu_i2f_cvt_lzc.sv
// Combinational leading-zero counter; returns W when the input is all zero.
// Zero latency, no handshake; shared with the other FPU normalisers.
module fpu_lzc #(
   parameter int  W  = 32,
   localparam int CW = $clog2(W) + 1
) (
   input  logic [W-1:0]  din_i,
   output logic [CW-1:0] cnt_o
);

   // Scanning upwards lets the most significant set bit have the final say.
   always_comb begin
      cnt_o = CW'(W);
      for (int i = 0; i < W; i++) begin
         if (din_i[i]) cnt_o = CW'(W - 1 - i);
      end
   end

endmodule

// File: rtl/fpu_i2f_cvt.sv
// Integer (32/64-bit, signed/unsigned) to IEEE-754 single converter, all RISC-V rounding modes.
// Latency 4 cycles from accepted dval to rdy pulse; one op in flight, dval while busy is dropped.
module fpu_i2f_cvt
   import fpu_i2f_cvt_pkg::*;
#(
   parameter int IW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   fpu_i2f_cvt_if.slave  cvt_if
);

   localparam int LZW = $clog2(IW) + 1;

   if (IW != 32 && IW != 64) begin : g_iw_check
      $error("fpu_i2f_cvt: IW must be 32 or 64");
   end

   i2f_state_e     state_q, state_d;
   logic [IW-1:0]  din_q, din_d;
   logic           uns_q, uns_d;
   logic [2:0]     rm_q, rm_d;
   logic           s_q, s_d;
   logic           zero_q, zero_d;
   logic [IW-1:0]  mag_q, mag_d;
   logic [IW-1:0]  norm_q, norm_d;
   logic [7:0]     exp_q, exp_d;
   logic [22:0]    frac_q, frac_d;
   logic           nx_q, nx_d;
   logic [31:0]    result_q, result_d;
   logic [4:0]     fflags_q, fflags_d;
   logic           rdy_q, rdy_d;

   logic [LZW-1:0] lz;
   logic           g, st, inc;

   fpu_lzc #(.W(IW)) u_lzc (
      .din_i (mag_q),
      .cnt_o (lz)
   );

   always_comb begin
      state_d  = state_q;
      din_d    = din_q;
      uns_d    = uns_q;
      rm_d     = rm_q;
      s_d      = s_q;
      zero_d   = zero_q;
      mag_d    = mag_q;
      norm_d   = norm_q;
      exp_d    = exp_q;
      frac_d   = frac_q;
      nx_d     = nx_q;
      result_d = result_q;
      fflags_d = fflags_q;
      rdy_d    = rdy_q;
      g        = norm_q[IW-SP_MANT_W-1];
      st       = |norm_q[IW-SP_MANT_W-2:0];
      inc      = round_inc(rm_q, s_q, norm_q[IW-SP_MANT_W], g, st);

      case (state_q)
         I2F_IDLE: begin
            rdy_d = 1'b0;
            if (cvt_if.dval) begin
               din_d   = cvt_if.din;
               uns_d   = cvt_if.is_unsigned;
               rm_d    = cvt_if.rm;
               state_d = I2F_ABS;
            end
         end
         I2F_ABS: begin
            // The most negative value negates onto itself, which is the correct unsigned magnitude.
            s_d     = !uns_q & din_q[IW-1];
            mag_d   = s_d ? ((~din_q) + IW'(1)) : din_q;
            zero_d  = (din_q == '0);
            state_d = I2F_NORM;
         end
         I2F_NORM: begin
            norm_d  = mag_q << lz;
            exp_d   = 8'(IW - 1) - 8'(lz);
            state_d = I2F_ROUND;
         end
         I2F_ROUND: begin
            // An all-ones mantissa that rounds up wraps the fraction to zero and bumps the exponent.
            frac_d = norm_q[IW-2 -: SP_MANT_W-1] + 23'(inc);
            if ((&norm_q[IW-1 -: SP_MANT_W]) && inc) exp_d = exp_q + 8'd1;
            nx_d    = g | st;
            state_d = I2F_PACK;
         end
         I2F_PACK: begin
            result_d           = zero_q ? 32'h0 : {s_q, exp_q + 8'(SP_BIAS), frac_q};
            fflags_d           = '0;
            fflags_d[FFLAG_NX] = !zero_q & nx_q;
            rdy_d              = 1'b1;
            state_d            = I2F_IDLE;
         end
         default: state_d = I2F_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= I2F_IDLE;
         din_q    <= '0;
         uns_q    <= 1'b0;
         rm_q     <= RM_RNE;
         s_q      <= 1'b0;
         zero_q   <= 1'b0;
         mag_q    <= '0;
         norm_q   <= '0;
         exp_q    <= '0;
         frac_q   <= '0;
         nx_q     <= 1'b0;
         result_q <= 32'h0;
         fflags_q <= '0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         din_q    <= din_d;
         uns_q    <= uns_d;
         rm_q     <= rm_d;
         s_q      <= s_d;
         zero_q   <= zero_d;
         mag_q    <= mag_d;
         norm_q   <= norm_d;
         exp_q    <= exp_d;
         frac_q   <= frac_d;
         nx_q     <= nx_d;
         result_q <= result_d;
         fflags_q <= fflags_d;
         rdy_q    <= rdy_d;
      end
   end

   assign cvt_if.result = result_q;
   assign cvt_if.fflags = fflags_q;
   assign cvt_if.rdy    = rdy_q;
   assign cvt_if.busy   = (state_q != I2F_IDLE);

endmodule
